lcd_frame_writer: RTL
=====================

# lcd_frame_writer

Display back end for the game: accepts the 32-character status string and its update trigger from the score/formatting stage and drives the board's HD44780-compatible 16x2 character LCD. After reset it runs the controller power-up and initialisation sequence. It then rewrites the whole screen on each update request, two rows of 16 characters each.

## Interface
Parameters:
- POWERUP_WAIT, 750000: cycles idle after reset before the first command (15 ms at 50 MHz).
- EN_CYCLES, 12: cycles LCD_EN is held high per transfer.
- CMD_WAIT, 2000: cycles idle after an ordinary transfer (40 µs).
- CLEAR_WAIT, 82000: cycles idle after the clear command 0x01 (1.64 ms).

Ports:
- clk, input, 1: master 50 MHz clock.
- reset, input, 1: synchronous, active-high reset.
- ASCII, input, [7:0] x [31:0]: screen characters. ASCII[i] goes to row i/16, column i%16.
- UpdateLCD, input, 1: update request. A rising edge marks new ASCII data.
- LCD_DATA, output, 8: LCD data bus.
- LCD_RS, output, 1: 0 for a command, 1 for character data.
- LCD_RW, output, 1: always 0 (write only).
- LCD_EN, output, 1: LCD enable strobe.
- LCD_ON, output, 1: panel power. Always 1.
- LCD_BLON, output, 1: backlight. Always 1.
- Busy, output, 1: high while initialising or while writing a frame.

## Operation
- Reset values: LCD_DATA=0x00, LCD_RS=0, LCD_EN=0, LCD_RW=0, LCD_ON=1, LCD_BLON=1, Busy=1. The pending flag and edge register are cleared.
- State machine: PWRUP → INIT → IDLE → FRAME → IDLE.
- PWRUP: counts POWERUP_WAIT cycles, then moves to INIT.
- INIT issues four commands in order:
  - 0x38: 8-bit bus, 2 lines, 5x8 font.
  - 0x0C: display on, cursor off.
  - 0x01: clear.
  - 0x06: increment, no shift.
- After INIT the block enters IDLE and Busy falls.
- Transfer primitive, for every command or character:
  - Setup: 1 cycle with LCD_RS and LCD_DATA valid and LCD_EN=0.
  - Strobe: EN_CYCLES cycles with LCD_EN=1.
  - Hold/wait: CMD_WAIT cycles, or CLEAR_WAIT cycles for command 0x01, with LCD_EN=0.
  - LCD_DATA and LCD_RS stay stable through the whole transfer.
- Update detection: UpdateLCD is registered, and a 0→1 transition sets the pending flag. A high level that persists causes no repeat.
- IDLE with pending set: the block snapshots all 32 ASCII bytes into an internal buffer, clears pending, raises Busy and enters FRAME.
- FRAME sends 34 transfers:
  - Command 0x80.
  - Data ASCII[0..15].
  - Command 0xC0.
  - Data ASCII[16..31].
- The snapshot makes the frame immune to ASCII changes while it is being sent.
- Updates during PWRUP, INIT or FRAME only set pending. Any number of them collapse into one follow-on frame, which uses the ASCII value present at the time of its snapshot.
- An update edge in the same cycle that a frame ends is kept: pending is set and the next frame starts.
- Reset mid-operation: on the next clk edge LCD_EN=0 and all outputs take their reset values. Any frame in progress is abandoned, and the full PWRUP and INIT sequence reruns.

## Timing
- Transfer length T = 1 + EN_CYCLES + wait, where wait is CMD_WAIT or CLEAR_WAIT.
- Init length = POWERUP_WAIT + 3·(1+EN_CYCLES+CMD_WAIT) + (1+EN_CYCLES+CLEAR_WAIT) cycles from reset deassertion. Busy falls in the cycle after this.
- Busy rises 2 cycles after an UpdateLCD rising edge seen in IDLE: 1 cycle for edge registration, 1 for the snapshot.
- Frame length = 34·(1+EN_CYCLES+CMD_WAIT) cycles. The first setup cycle is the cycle after Busy rises.
- Output registers: all LCD_* outputs come straight from flip-flops.
- Counters: sized to log2 of the largest wait. No wrap-around is permitted within a state.

## Configuration
- LCD_SANITIZE_EN defined: any snapshot byte outside 0x20–0x7E is replaced with 0x20 (space) before it is written.
- LCD_SANITIZE_EN undefined: bytes are written unmodified.
- The macro has no effect on command bytes or timing.

## Test plan
All scenarios use POWERUP_WAIT=20, EN_CYCLES=2, CMD_WAIT=4, CLEAR_WAIT=8, which gives T=7 (clear T=11), init = 52 cycles and frame = 238 cycles.
- Reset release → LCD_DATA sequence 0x38, 0x0C, 0x01, 0x06, each with RS=0 and an EN high for exactly 2 cycles. Busy falls 52 cycles after reset deasserts.
- ASCII[i]=0x41+i (i<26, rest 0x30), UpdateLCD pulse in IDLE → EN strobes carry:
  - 0x80, 0x41…0x50 (RS=1), 0xC0, 0x51…0x5A then 0x30 ×6.
  - Busy is high for 238 cycles.
- ASCII changed to all 0x20 during a frame, plus 3 UpdateLCD pulses → current frame unchanged. Exactly one further frame follows, all 0x20.
- reset asserted at cycle 100 of a frame → EN=0 the next cycle. The init sequence repeats, and no further frame is sent unless an update arrives.
- UpdateLCD held high for 500 cycles → exactly one frame.
- ASCII[5]=0x07, ASCII[6]=0xFF → written as 0x20, 0x20 with LCD_SANITIZE_EN defined; written as 0x07, 0xFF without it.

Source files
------------

// File: rtl/lcd_frame_writer.sv
// HD44780 16x2 character LCD back end: power-up wait, init commands, then full-screen rewrite per update.
// Optional build macro LCD_SANITIZE_EN replaces non-printable snapshot bytes with spaces.
module lcd_frame_writer #(
    parameter int POWERUP_WAIT = 750000,
    parameter int EN_CYCLES    = 12,
    parameter int CMD_WAIT     = 2000,
    parameter int CLEAR_WAIT   = 82000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0][7:0] ASCII,
    input  logic            UpdateLCD,
    output logic [7:0]      LCD_DATA,
    output logic            LCD_RS,
    output logic            LCD_RW,
    output logic            LCD_EN,
    output logic            LCD_ON,
    output logic            LCD_BLON,
    output logic            Busy
);
    localparam int MAX_A = (POWERUP_WAIT > CLEAR_WAIT) ? POWERUP_WAIT : CLEAR_WAIT;
    localparam int MAX_B = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
    localparam int MAXW  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAXW > 1) ? $clog2(MAXW) : 1;

    localparam logic [1:0] S_PWRUP = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_IDLE  = 2'd2;
    localparam logic [1:0] S_FRAME = 2'd3;

    localparam logic [1:0] P_SETUP  = 2'd0;
    localparam logic [1:0] P_STROBE = 2'd1;
    localparam logic [1:0] P_WAIT   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       phase;
    logic [CW-1:0]    cnt;
    logic [5:0]       idx;
    logic [31:0][7:0] snap;
    logic             upd_q;
    logic             pending;

    logic [5:0]       nxt_idx;
    logic [4:0]       sel;
    logic [7:0]       nxt_data;
    logic             nxt_rs;
    logic [CW-1:0]    wait_last;
    logic             last_xfer;
    logic             rise;

    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;

    function automatic logic [7:0] clean(input logic [7:0] b);
`ifdef LCD_SANITIZE_EN
        return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
`else
        return b;
`endif
    endfunction

    // Frame slot 0 is the row-1 address, slot 17 the row-2 address; others map to snapshot bytes.
    always_comb begin
        nxt_idx  = idx + 6'd1;
        sel      = nxt_idx[4:0] - ((nxt_idx <= 6'd16) ? 5'd1 : 5'd2);
        nxt_rs   = 1'b0;
        nxt_data = 8'h00;
        if (state == S_INIT) begin
            case (nxt_idx[1:0])
                2'd1:    nxt_data = 8'h0C;
                2'd2:    nxt_data = 8'h01;
                default: nxt_data = 8'h06;
            endcase
        end else if (nxt_idx == 6'd17) begin
            nxt_data = 8'hC0;
        end else begin
            nxt_rs   = 1'b1;
            nxt_data = snap[sel];
        end
        wait_last = (!LCD_RS && LCD_DATA == 8'h01) ? CW'(CLEAR_WAIT - 1) : CW'(CMD_WAIT - 1);
        last_xfer = (state == S_INIT) ? (idx == 6'd3) : (idx == 6'd33);
        rise      = UpdateLCD & ~upd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_PWRUP;
            phase    <= P_SETUP;
            cnt      <= '0;
            idx      <= '0;
            snap     <= '0;
            upd_q    <= 1'b0;
            pending  <= 1'b0;
            LCD_DATA <= '0;
            LCD_RS   <= 1'b0;
            LCD_EN   <= 1'b0;
            Busy     <= 1'b1;
        end else begin
            upd_q <= UpdateLCD;
            if (rise)
                pending <= 1'b1;
            case (state)
                S_PWRUP: begin
                    if (cnt == CW'(POWERUP_WAIT - 1)) begin
                        state    <= S_INIT;
                        phase    <= P_SETUP;
                        idx      <= '0;
                        cnt      <= '0;
                        LCD_DATA <= 8'h38;
                        LCD_RS   <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (pending) begin
                        // An edge arriving in the snapshot cycle stays pending for a follow-on frame.
                        pending <= rise;
                        for (int unsigned i = 0; i < 32; i++)
                            snap[i] <= clean(ASCII[i]);
                        Busy     <= 1'b1;
                        state    <= S_FRAME;
                        phase    <= P_SETUP;
                        idx      <= '0;
                        cnt      <= '0;
                        LCD_DATA <= 8'h80;
                        LCD_RS   <= 1'b0;
                    end
                end
                default: begin
                    case (phase)
                        P_SETUP: begin
                            LCD_EN <= 1'b1;
                            phase  <= P_STROBE;
                            cnt    <= '0;
                        end
                        P_STROBE: begin
                            if (cnt == CW'(EN_CYCLES - 1)) begin
                                LCD_EN <= 1'b0;
                                phase  <= P_WAIT;
                                cnt    <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        default: begin
                            if (cnt == wait_last) begin
                                cnt <= '0;
                                if (last_xfer) begin
                                    state <= S_IDLE;
                                    Busy  <= 1'b0;
                                end else begin
                                    idx      <= nxt_idx;
                                    phase    <= P_SETUP;
                                    LCD_DATA <= nxt_data;
                                    LCD_RS   <= nxt_rs;
                                end
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    endcase
                end
            endcase
        end
    end
endmodule
